// File: rtl/mulred_arb_pkg.sv
// Shared types and helpers for the multiply-reduce arbiter.
// Optional build macro: MULRED_ARB_PRIO0_EN (requester 0 gets absolute priority).
package mulred_arb_pkg;

    // Default coefficient width
    localparam int unsigned COE_WIDTH_DEF = 39;

    // Tag index width covers the largest supported requester count (8)
    localparam int unsigned TAG_IDX_W = 3;

    // Delay-line record: operation valid plus the issuing requester index
    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } mr_tag_t;

    // Width of the round-robin pointer for n requesters
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mulred_rr_arb.sv
// Combinational round-robin grant logic for mulred_arb.
// Optional build macro: MULRED_ARB_PRIO0_EN (requester 0 wins whenever it requests).
module mulred_rr_arb
    import mulred_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               hold,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0] rr_req;
    logic [PTR_W-1:0]   idx;
    logic               found;

    // Search from ptr upward with wrap; first requester found wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
`ifdef MULRED_ARB_PRIO0_EN
        rr_req = req & ~NUM_REQ'(1);
        if (req[0]) begin
            grant[0] = 1'b1;
            found    = 1'b1;
        end
`else
        rr_req = req;
`endif
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = PTR_W'((int'(ptr) + k) % int'(NUM_REQ));
            if (!found && rr_req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        if (hold) begin
            grant = '0;
        end
    end

endmodule

// File: rtl/mulred_arb.sv
// Arbiter sharing one fixed-latency multiply-reduce unit among NUM_REQ requesters.
// Optional build macro: MULRED_ARB_PRIO0_EN (requester 0 has absolute priority and
// its grants do not move the round-robin pointer).
module mulred_arb
    import mulred_arb_pkg::*;
#(
    parameter int unsigned COE_WIDTH  = COE_WIDTH_DEF,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MULRED_LAT = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_hold,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*COE_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*COE_WIDTH-1:0] req_b,
    output logic [COE_WIDTH-1:0]         mr_a,
    output logic [COE_WIDTH-1:0]         mr_b,
    input  logic [COE_WIDTH-1:0]         mr_res,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [COE_WIDTH-1:0]         rsp_data,
    output logic                         busy
);

    localparam int unsigned PTR_W = ptr_width(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MULRED_LAT + 3);

    logic [NUM_REQ-1:0]   grant;
    logic                 issue;
    logic                 retire;
    logic                 ptr_upd;
    logic [PTR_W-1:0]     gnt_idx;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [COE_WIDTH-1:0] sel_a, sel_b;
    logic [COE_WIDTH-1:0] mr_a_q, mr_b_q;
    logic [COE_WIDTH-1:0] rsp_data_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [NUM_REQ-1:0]   rsp_onehot;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    mr_tag_t              tag_q [MULRED_LAT+1];

    // Reset also masks grants so req_ready stays low while rst_n is asserted
    mulred_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .hold  (i_hold | ~rst_n),
        .grant (grant)
    );

    assign req_ready = grant;
    assign issue     = |grant;
    assign retire    = |rsp_valid_q;

    // Encode the grant and mux the winning operands
    always_comb begin
        gnt_idx = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                gnt_idx = PTR_W'(i);
                sel_a   = req_a[i*COE_WIDTH +: COE_WIDTH];
                sel_b   = req_b[i*COE_WIDTH +: COE_WIDTH];
            end
        end
    end

    // Pointer advances past the winner; in priority mode requester 0 leaves it alone
    always_comb begin
`ifdef MULRED_ARB_PRIO0_EN
        ptr_upd = issue & ~grant[0];
`else
        ptr_upd = issue;
`endif
        ptr_d = ptr_q;
        if (ptr_upd) begin
            ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    // In-flight count: issues in, delivered responses out
    always_comb begin
        cnt_d = cnt_q;
        case ({issue, retire})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Decode the tag leaving the delay line into a response strobe
    always_comb begin
        rsp_onehot = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            rsp_onehot[i] = tag_q[MULRED_LAT].valid && (tag_q[MULRED_LAT].idx == TAG_IDX_W'(i));
        end
    end

    // Pointer and in-flight counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Operand registers hold their value between issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mr_a_q <= '0;
            mr_b_q <= '0;
        end else if (issue) begin
            mr_a_q <= sel_a;
            mr_b_q <= sel_b;
        end
    end

    // Tag delay line; last stage lines up with mr_res
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= int'(MULRED_LAT); k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0].valid <= issue;
            tag_q[0].idx   <= TAG_IDX_W'(gnt_idx);
            for (int k = 1; k <= int'(MULRED_LAT); k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Response register: one-cycle strobe, data held until the next result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_onehot;
            if (tag_q[MULRED_LAT].valid) begin
                rsp_data_q <= mr_res;
            end
        end
    end

    assign mr_a      = mr_a_q;
    assign mr_b      = mr_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (cnt_q != '0);

endmodule

// File: doc/mulred_arb.md
MULRED_ARB -- requirements
Module: mulred_arb

Interface
REQ-001 SHALL have parameter COE_WIDTH, default 39, coefficient width.
REQ-002 SHALL have parameter NUM_REQ, default 4, requester count (2..8).
REQ-003 SHALL have parameter MULRED_LAT, default 8, fixed cycles from mr_a/mr_b to mr_res of the shared multiply-reduce unit.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_hold  in  1  blocks new issues.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester grant.
- req_a  in  NUM_REQ*COE_WIDTH  packed operands A; slot i at [i*COE_WIDTH +: COE_WIDTH].
- req_b  in  NUM_REQ*COE_WIDTH  packed operands B; same packing.
- mr_a  out  COE_WIDTH  operand A to the shared unit.
- mr_b  out  COE_WIDTH  operand B to the shared unit.
- mr_res  in  COE_WIDTH  result from the shared unit.
- rsp_valid  out  NUM_REQ  one-hot result strobe.
- rsp_data  out  COE_WIDTH  result, shared by all requesters.
- busy  out  1  any operation in flight.

Function
REQ-005 SHALL assert at most one req_ready bit per cycle; req_ready SHALL be all-zero when i_hold=1 or no req_valid is set.
REQ-006 SHALL grant round-robin: the search starts at pointer P; the first set req_valid at index P, P+1, ..., wrapping modulo NUM_REQ, wins.
REQ-007 SHALL load P with granted index+1 (mod NUM_REQ) on a grant and SHALL hold P otherwise.
REQ-008 SHALL accept one issue per cycle; the issue occurs when req_valid[i]&req_ready[i].
REQ-009 SHALL register the granted operands into mr_a/mr_b one cycle after the issue; mr_a/mr_b SHALL hold their values in cycles without an issue.
REQ-010 SHALL carry a valid bit and the requester index through a delay line of length MULRED_LAT+1 aligned with mr_res.
REQ-011 SHALL register mr_res into rsp_data and pulse the tagged rsp_valid bit for exactly one cycle; total latency is issue cycle t to rsp_valid at cycle t+MULRED_LAT+2.
REQ-012 SHALL hold rsp_data between responses; rsp_valid has no backpressure.
REQ-013 SHALL keep an in-flight counter (width clog2(MULRED_LAT+3)); an issue and a retire in the same cycle leave the counter unchanged.
REQ-014 SHALL drive busy=1 exactly when the counter is non-zero.
REQ-015 SHALL treat a rising edge of i_hold as blocking new issues only; in-flight operations SHALL complete normally.
REQ-016 SHALL preserve issue order: responses leave in issue order, back-to-back at full throughput.

Reset
REQ-017 SHALL, while rst_n=0, force: req_ready=0, rsp_valid=0, rsp_data=0, mr_a=0, mr_b=0, busy=0, P=0, counter=0, and all delay-line valid bits=0.
REQ-018 SHALL discard every in-flight operation when reset is asserted mid-operation; no rsp_valid may appear for pre-reset issues after rst_n deasserts.

Configuration
REQ-019 SHALL, with macro MULRED_ARB_PRIO0_EN defined, give requester 0 absolute priority; the remaining requesters are arbitrated round-robin among themselves when req_valid[0]=0, and a grant to requester 0 leaves P unchanged.
REQ-020 SHALL, without MULRED_ARB_PRIO0_EN, apply pure round-robin per REQ-006/007.

Structure
REQ-021 SHALL place the default COE_WIDTH, the arbitration pointer width function, and the tag record type (valid plus index) in the shared ntt_intt package/defines.
REQ-022 SHALL implement the grant logic in one sub-module, mulred_rr_arb (inputs: request vector, pointer, hold; output: one-hot grant), which is purely combinational; all state resides in mulred_arb.

Verification
REQ-023 SHALL cover a single issue: req_valid=0001, a=3, b=5, reference unit modelled as a*b mod Q -> rsp_valid=0001 with rsp_data=15 exactly MULRED_LAT+2 cycles later, and busy high for that interval.
REQ-024 SHALL cover all four requesters valid continuously, P=0 -> grants in order 0,1,2,3,0,... one per cycle, and responses tagged in the same order back-to-back.
REQ-025 SHALL cover req_valid=1010 with P=2 -> grant to 3, then P=0 -> grant to 1.
REQ-026 SHALL cover i_hold=1 with 3 operations in flight -> no req_ready, all 3 responses delivered, and busy low after the last one.
REQ-027 SHALL cover rst_n pulsed low with 5 operations in flight -> rsp_valid=0 for the following MULRED_LAT+3 cycles, with counter=0 and P=0.
REQ-028 SHALL cover MULRED_ARB_PRIO0_EN defined with req_valid=1111 held -> requester 0 granted every cycle, and no other requester granted until req_valid[0] drops.
